alu_issue_stage: RTL



---
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALUOp/funct3/funct7 into an ALU operation code, selects SrcB and
// holds each operation in a 2-entry skid buffer. Define ALU_ISSUE_ILLEGAL_DETECT_EN to drive `illegal`.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     ALUSrc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1100);

    logic [OPCODE_LENGTH-1:0] raw_op;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;
    logic [DATA_WIDTH-1:0]    src_b_in;

    // Shared ALU-function decode for R-type and I-type; R-type additionally gates on funct7.
    always_comb begin
        raw_op  = OP_AND;
        dec_ill = 1'b0;
        case (ALUOp)
            2'b00: raw_op = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000:  raw_op = OP_EQ;
                    3'b001:  raw_op = OP_NE;
                    3'b100:  raw_op = OP_LT;
                    3'b101:  raw_op = OP_GE;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000:  raw_op = OP_ADD;
                    3'b111:  raw_op = OP_AND;
                    3'b110:  raw_op = OP_OR;
                    3'b100:  raw_op = OP_XOR;
                    3'b010:  raw_op = OP_LT;
                    default: dec_ill = 1'b1;
                endcase
                if (ALUOp == 2'b10) begin
                    if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                        raw_op = OP_SUB;
                    end else if (funct7 != 7'b0000000) begin
                        dec_ill = 1'b1;
                    end
                end
            end
        endcase
        dec_op = dec_ill ? OP_AND : raw_op;
    end

    assign src_b_in = ALUSrc ? imm : rs2_data;

    logic                     main_valid_reg, main_valid_next;
    logic                     skid_valid_reg, skid_valid_next;
    logic                     in_ready_reg;
    logic                     load_main_in, load_main_skid, load_skid;
    logic [DATA_WIDTH-1:0]    main_a_reg, main_b_reg, skid_a_reg, skid_b_reg;
    logic [OPCODE_LENGTH-1:0] main_op_reg, skid_op_reg;
    logic                     take_in, take_out;

    assign take_in  = in_valid & in_ready_reg;
    assign take_out = main_valid_reg & out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        load_main_in    = 1'b0;
        load_main_skid  = 1'b0;
        load_skid       = 1'b0;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg) begin
            load_main_in    = take_in;
            main_valid_next = take_in;
        end else if (!skid_valid_reg) begin
            if (take_in && take_out) begin
                load_main_in = 1'b1;
            end else if (take_in) begin
                load_skid       = 1'b1;
                skid_valid_next = 1'b1;
            end else if (take_out) begin
                main_valid_next = 1'b0;
            end
        end else if (take_out) begin
            // FULL never accepts input, so draining just promotes the skid entry.
            load_main_skid  = 1'b1;
            skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            main_a_reg     <= '0;
            main_b_reg     <= '0;
            main_op_reg    <= OP_AND;
            skid_a_reg     <= '0;
            skid_b_reg     <= '0;
            skid_op_reg    <= OP_AND;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= ~skid_valid_next;
            if (load_main_in) begin
                main_a_reg  <= rs1_data;
                main_b_reg  <= src_b_in;
                main_op_reg <= dec_op;
            end else if (load_main_skid) begin
                main_a_reg  <= skid_a_reg;
                main_b_reg  <= skid_b_reg;
                main_op_reg <= skid_op_reg;
            end
            if (load_skid) begin
                skid_a_reg  <= rs1_data;
                skid_b_reg  <= src_b_in;
                skid_op_reg <= dec_op;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_DETECT_EN
    logic main_ill_reg, skid_ill_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_ill_reg <= 1'b0;
            skid_ill_reg <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_ill_reg <= dec_ill;
            end else if (load_main_skid) begin
                main_ill_reg <= skid_ill_reg;
            end
            if (load_skid) begin
                skid_ill_reg <= dec_ill;
            end
        end
    end

    assign illegal = main_ill_reg;
`else
    assign illegal = 1'b0;
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign SrcA      = main_a_reg;
    assign SrcB      = main_b_reg;
    assign Operation = main_op_reg;

endmodule
